// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the fifo_level block.
package fifo_pkg;

    localparam int FIFO_WIDTH    = 16;
    localparam int FIFO_DEPTH    = 32;
    localparam int FIFO_ADDWIDTH = 5;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int ADDWIDTH = 5
) (
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [ADDWIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]    wr_data_i,
    input  logic [ADDWIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]    rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: no reset on the array; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A same-cycle write to rd_addr_i lands after the edge, so readers see old data.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_LEVEL_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int ADDWIDTH = FIFO_ADDWIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic                read,
    input  logic                flush,
    input  logic                clear_err,
    input  logic [WIDTH-1:0]    dataIn,
    input  logic [ADDWIDTH:0]   af_thresh,
    input  logic [ADDWIDTH:0]   ae_thresh,
    output logic [WIDTH-1:0]    dataOut,
    output logic [ADDWIDTH:0]   count,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [ADDWIDTH:0] FULL_CNT = (ADDWIDTH+1)'(DEPTH);

    logic [ADDWIDTH-1:0] head_q, head_d;
    logic [ADDWIDTH-1:0] tail_q, tail_d;
    logic [ADDWIDTH:0]   count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                wr_ok, rd_ok;
    logic [WIDTH-1:0]    rd_data;
    fifo_status_t        status;

    assign status.full         = (count_q == FULL_CNT);
    assign status.empty        = (count_q == '0);
    assign status.almost_full  = (count_q >= af_thresh);
    assign status.almost_empty = (count_q <= ae_thresh);
    assign status.overflow     = ovf_q;
    assign status.underflow    = unf_q;

    assign wr_ok = write & ~status.full;
    assign rd_ok = read  & ~status.empty;

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) head_d = head_q + 1'b1;
            if (rd_ok) tail_d = tail_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // A new event wins over a same-cycle clear.
        ovf_d = (write & status.full)  | (ovf_q & ~clear_err);
        unf_d = (read  & status.empty) | (unf_q & ~clear_err);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_mem #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDWIDTH (ADDWIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_ok & ~flush),
        .wr_addr_i (head_q),
        .wr_data_i (dataIn),
        .rd_addr_i (tail_q),
        .rd_data_o (rd_data)
    );

`ifdef FIFO_LEVEL_FWFT_EN
    assign dataOut = status.empty ? '0 : rd_data;
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    assign dout_d = (rd_ok & ~flush) ? rd_data : dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dataOut = dout_q;
`endif

    assign count        = count_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fifo_level;

    localparam int W  = 16;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          write, read, flush, clear_err;
    logic [W-1:0]  dataIn;
    logic [AW:0]   af_thresh, ae_thresh;
    logic [W-1:0]  dataOut;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    fifo_level #(.WIDTH(W), .DEPTH(D), .ADDWIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .flush        (flush),
        .clear_err    (clear_err),
        .dataIn       (dataIn),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .dataOut      (dataOut),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, sticky flags, and the last word read.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_ovf, m_unf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic f,
                              input logic c, input logic [W-1:0] d);
        bit was_full  = (q.size() == D);
        bit was_empty = (q.size() == 0);
        m_ovf = (w && was_full)  || (m_ovf && !c);
        m_unf = (r && was_empty) || (m_unf && !c);
        if (f) begin
            q.delete();
        end else begin
            if (r && !was_empty) m_dout = q.pop_front();
            if (w && !was_full)  q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int n = q.size();
        logic [W-1:0] exp_dout;
`ifdef FIFO_LEVEL_FWFT_EN
        exp_dout = (n > 0) ? q[0] : '0;
`else
        exp_dout = m_dout;
`endif
        check({tag, "_count"}, 32'(count), 32'(n));
        check({tag, "_full"},  32'(full),  32'(n == D));
        check({tag, "_empty"}, 32'(empty), 32'(n == 0));
        check({tag, "_af"},    32'(almost_full),  32'(n >= int'(af_thresh)));
        check({tag, "_ae"},    32'(almost_empty), 32'(n <= int'(ae_thresh)));
        check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        check({tag, "_unf"},   32'(underflow), 32'(m_unf));
        check({tag, "_dout"},  32'(dataOut),   32'(exp_dout));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input string tag, input logic w, input logic r, input logic f,
                        input logic c, input logic [W-1:0] d);
        write = w; read = r; flush = f; clear_err = c; dataIn = d;
        @(posedge clk);
        #1;
        model_step(w, r, f, c, d);
        write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0; read = 1'b0; flush = 1'b0; clear_err = 1'b0;
        dataIn = '0;
        af_thresh = 6'd30;
        ae_thresh = 6'd2;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill to full with 0..31.
        for (int i = 0; i < D; i++) step("fill", 1'b1, 1'b0, 1'b0, 1'b0, 16'(i));

        // Full: write rejected, read accepted, overflow set.
        step("full_wr_rd", 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);

        // Drain, including reads on empty that set underflow.
        for (int i = 0; i < D; i++) step("drain", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step("extra_rd", 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Clear with a simultaneous underflow event keeps the flag; plain clear drops it.
        step("clr_setwins", 1'b0, 1'b1, 1'b0, 1'b1, '0);
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Pointer wrap with count held at 1.
        step("seed", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
        for (int i = 0; i < 100; i++) step("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 16'(16'h0200 + i));
        step("wrap_end", 1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Flush overrides a same-cycle write; storage reused afterwards.
        for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0300 + i));
        step("flush", 1'b1, 1'b0, 1'b1, 1'b0, 16'hDEAD);
        step("post_flush_wr", 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
        step("post_flush_rd", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step("post_flush_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Output timing of a single word.
        step("a5_wr", 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5);
        step("a5_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step("a5_rd", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step("a5_after", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Reach count=17 with overflow set, then reset between clock edges.
        for (int i = 0; i < D; i++) step("refill", 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0400 + i));
        step("ovf_again", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 15; i++) step("to17", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Random traffic with drifting write/read bias and thresholds.
        for (int i = 0; i < 800; i++) begin
            int bias = ((i / 100) % 2 == 0) ? 70 : 30;
            logic w = ($urandom_range(0, 99) < bias);
            logic r = ($urandom_range(0, 99) < (100 - bias));
            logic f = ($urandom_range(0, 63) == 0);
            logic c = ($urandom_range(0, 15) == 0);
            if (i % 50 == 0) begin
                af_thresh = 6'($urandom_range(0, 33));
                ae_thresh = 6'($urandom_range(0, 33));
            end
            step("rand", w, r, f, c, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; SHALL equal 2**ADDWIDTH.
REQ-003 SHALL have parameter ADDWIDTH, default 5: pointer width.
REQ-004 Ports SHALL be:
 - clk  input  1  sole clock; all state on rising edge.
 - reset  input  1  asynchronous, active-high reset.
 - write  input  1  write request.
 - read  input  1  read request.
 - flush  input  1  synchronous clear of contents.
 - clear_err  input  1  synchronous clear of sticky error flags.
 - dataIn  input  WIDTH  write data.
 - af_thresh  input  ADDWIDTH+1  almost-full level.
 - ae_thresh  input  ADDWIDTH+1  almost-empty level.
 - dataOut  output  WIDTH  read data.
 - count  output  ADDWIDTH+1  current occupancy, 0..DEPTH.
 - full, empty, almost_full, almost_empty  output  1 each  status flags.
 - overflow, underflow  output  1 each  sticky error flags.

Function
REQ-005 Write SHALL be accepted (wr_ok) iff write=1 and full=0; the word is stored at head, and head increments, wrapping DEPTH-1 to 0.
REQ-006 Read SHALL be accepted (rd_ok) iff read=1 and empty=0; tail increments, wrapping DEPTH-1 to 0.
REQ-007 With full=1, write SHALL be rejected even if a read is accepted in the same cycle.
REQ-008 With empty=1, read SHALL be rejected even if a write is accepted in the same cycle.
REQ-009 count SHALL update each cycle to count + wr_ok - rd_ok; simultaneous wr_ok and rd_ok SHALL leave count unchanged.
REQ-010 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both derived from the registered count.
REQ-011 almost_full SHALL equal (count >= af_thresh), and almost_empty SHALL equal (count <= ae_thresh), both combinational on count and threshold.
REQ-012 overflow SHALL set on the cycle after write=1 with full=1, and underflow on the cycle after read=1 with empty=1; both SHALL hold until clear_err or reset.
REQ-013 If clear_err and a new error event occur in the same cycle, the flag SHALL set (set wins).
REQ-014 flush SHALL, next edge, zero head, tail and count, and SHALL override write/read that cycle; stored data is not cleared and error flags are unaffected.
REQ-015 Without the configuration macro, dataOut SHALL be registered: it loads mem[tail] on the edge that accepts a read (valid one cycle after read) and holds otherwise.
REQ-016 Storage SHALL read old data when a write and a read target the same address in one cycle; this can only occur with count==0 or DEPTH, which REQ-007 and REQ-008 exclude.

Reset
REQ-017 Reset SHALL asynchronously force head=0, tail=0, count=0, dataOut=0, overflow=0 and underflow=0, giving empty=1 and full=0.
REQ-018 Reset asserted mid-operation SHALL discard all contents; the first cycle after deassertion behaves as a freshly reset FIFO.
REQ-019 Storage array contents SHALL NOT require reset.

Configuration
REQ-020 Macro FIFO_LEVEL_FWFT_EN SHALL select first-word-fall-through when defined: dataOut = mem[tail] combinationally whenever empty=0, and the next word appears the cycle after an accepted read.
REQ-021 When FIFO_LEVEL_FWFT_EN is undefined, the registered-read behaviour of REQ-015 SHALL apply; flags and count SHALL be identical in both modes.

Structure
REQ-022 Shared package fifo_pkg SHALL hold the default WIDTH, DEPTH and ADDWIDTH constants and a status typedef bundling full, empty, almost_full, almost_empty, overflow and underflow.
REQ-023 Storage SHALL be a sub-module fifo_mem: DEPTH x WIDTH, one write port, one read port, no reset; the pointer, count and flag logic SHALL reside in fifo_level.

Verification (DEPTH=32, af_thresh=30, ae_thresh=2 unless stated)
REQ-024 Reset, then 32 writes of 0x0000..0x001F -> count=32, full=1, almost_full from count=30, empty=0, overflow=0.
REQ-025 From full, write 0xBEEF with read=1 -> read accepted, write rejected, count=31, overflow=1; then 32 reads return 0x0001..0x001F then nothing, empty=1; one extra read -> underflow=1.
REQ-026 Alternate 100 write/read pairs from count=1 (pointer wrap) -> count stays 1, data returns in order, no flag toggles.
REQ-027 Write 5 words, then assert flush with write=1 -> count=0, empty=1; the next write of 0x1234 reads back as 0x1234.
REQ-028 With FIFO_LEVEL_FWFT_EN, write 0xA5A5 -> dataOut=0xA5A5 the cycle after the write with no read; without the macro, dataOut=0xA5A5 one cycle after read.
REQ-029 Assert reset while count=17 with overflow=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
